reverse_bits_arbiter: RTL and testbench
=======================================

Name: reverse_bits_arbiter

Overview:
- Shares one bit-reversal datapath between two requesters, A and B, each with its own valid/ready handshake.
- Grants requesters round-robin, registers the reversed word, and presents it on a single response channel tagged with the requester ID.
- Sits between the stimulus or producer logic and the reversal function. It replaces the two dedicated reversal paths with one time-shared unit.

Parameters:
- WIDTH, 8, data width of request and response words.
- CNT_W, 16, width of the per-requester grant counters (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_valid  input  1  requester A has a word.
- a_data  input  WIDTH  requester A word.
- a_ready  output  1  A's word is accepted this cycle.
- b_valid  input  1  requester B has a word.
- b_data  input  WIDTH  requester B word.
- b_ready  output  1  B's word is accepted this cycle.
- rsp_valid  output  1  response register holds a result.
- rsp_data  output  WIDTH  bit-reversed word: rsp_data[i] = src[WIDTH-1-i].
- rsp_id  output  1  source of the response: 0 = A, 1 = B.
- rsp_ready  input  1  consumer accepts the response.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; rsp_valid=0, rsp_data=0, rsp_id=0.
  - last_grant=1, so A wins the first contest.
  - a_ready=b_ready=0 while rst is high.
- States:
  - IDLE: response register empty.
  - HOLD: response register full, waiting for the consumer.
- can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
- Arbitration is combinational, evaluated only when can_accept=1:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- a_ready / b_ready:
  - Equal to can_accept & grant, for the matching requester only.
  - At most one of them is high in any cycle.
  - ready never depends on the same requester's valid being low.
- On a transfer (x_valid & x_ready), at the next edge:
  - rsp_data <= reverse(x_data); rsp_id <= x.
  - rsp_valid <= 1; last_grant <= x; state -> HOLD.
- HOLD:
  - rsp_valid=1; rsp_data and rsp_id are held stable while rsp_ready=0.
  - rsp_ready=1 with no new grant: rsp_valid <= 0, state -> IDLE.
  - rsp_ready=1 with a new grant in the same cycle: the new result loads, state stays HOLD. This gives back-to-back throughput of 1 word/cycle.
- Latency: a request accepted at edge N appears on rsp_* after edge N+1 (1-cycle registered).
- Requesters must hold valid and data until ready. The arbiter does not latch unaccepted inputs.
- Fairness: under continuous dual requests, grants alternate A, B, A, B… and neither requester waits more than one grant.
- Reset mid-operation: a pending response is discarded, last_grant returns to 1, and no ready is issued.
- rsp_ready while state==IDLE is ignored.

Optional Feature:
- Macro: REVERSE_ARB_STATS_EN.
- Defined:
  - Adds outputs a_grant_cnt and b_grant_cnt, each CNT_W bits.
  - Each counter increments on its requester's transfer, saturates at all-ones, and is cleared by rst.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Package reverse_arb_pkg holds:
  - State encoding constants ST_IDLE=1'b0, ST_HOLD=1'b1.
  - ID constants ID_A=1'b0, ID_B=1'b1.
  - A parameterised reverse function.
- One sub-module: reverse_bits_core, a combinational WIDTH-bit reversal. It is instantiated once on the mux output (selected requester data).

Test Plan:
- Single request: a_valid=1, a_data=8'b0000_0001, rsp_ready=1 → a_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=8'b1000_0000, rsp_id=0.
- Contention after reset: a_data=8'hF0 and b_data=8'h0C both valid, held → A granted first (rsp 8'h0F, id 0), then B (rsp 8'h30, id 1); alternation continues for 8 cycles.
- Backpressure: rsp_ready=0 for 3 cycles with A pending → a_ready=b_ready=0 and rsp_data stable. rsp_ready=1 → next word loads the same cycle it is released.
- Back-to-back: A streams 8'h01, 8'h02, 8'h03 with rsp_ready=1 → responses 8'h80, 8'h40, 8'hC0 on consecutive cycles.
- Reset mid-HOLD: rsp_valid=1, rsp_data=8'hAA, assert rst asynchronously → rsp_valid=0 and rsp_data=0 immediately. After release, A wins a tie.
- With REVERSE_ARB_STATS_EN and CNT_W=2: 5 A transfers → a_grant_cnt saturates at 2'b11, b_grant_cnt=0.

Source files
------------

// File: rtl/reverse_bits_arbiter_pkg.sv
// Shared types, constants and the bit-reversal helper for the reverse_bits_arbiter slice.
package reverse_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // Widest word the reversal helper supports; callers pass their actual width.
    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = $clog2(MAX_W);

    function automatic logic [MAX_W-1:0] reverse_bits(input logic [MAX_W-1:0] x,
                                                      input int unsigned      w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r[IDX_W'(i)] = x[IDX_W'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reverse_bits_arbiter_if.sv
// Two-requester request channels plus the shared tagged response channel.
interface reverse_bits_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data, rsp_ready,
        input  a_ready, b_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, rsp_ready,
        output a_ready, b_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/reverse_bits_arbiter_core.sv
// Combinational WIDTH-bit reversal: y[i] = x[WIDTH-1-i].
module reverse_bits_core
    import reverse_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    logic [MAX_W-1:0] rev_wide;

    assign rev_wide = reverse_bits(MAX_W'(x), WIDTH);
    assign y        = WIDTH'(rev_wide);

endmodule

// File: rtl/reverse_bits_arbiter.sv
// Round-robin arbiter sharing one bit-reversal unit between requesters A and B.
// Optional grant counters are enabled with REVERSE_ARB_STATS_EN.
module reverse_bits_arbiter
    import reverse_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
`ifdef REVERSE_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    reverse_bits_arbiter_if.slave   bus
`ifdef REVERSE_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]        a_grant_cnt,
    output logic [CNT_W-1:0]        b_grant_cnt
`endif
);

    state_e           state, state_n;
    logic             last_grant, last_grant_n;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_n;
    logic             rsp_id_q, rsp_id_n;

    logic             can_accept;
    logic             gnt_a, gnt_b;
    logic             ready_a, ready_b;
    logic [WIDTH-1:0] sel_data, rev_data;

    // A slot opens when the register is empty or is being drained this cycle.
    assign can_accept = (state == ST_IDLE) || (state == ST_HOLD && bus.rsp_ready);
    assign gnt_a      = bus.a_valid && (!bus.b_valid || last_grant == ID_B);
    assign gnt_b      = bus.b_valid && (!bus.a_valid || last_grant == ID_A);
    assign ready_a    = !rst && can_accept && gnt_a;
    assign ready_b    = !rst && can_accept && gnt_b;

    assign sel_data   = gnt_b ? bus.b_data : bus.a_data;

    reverse_bits_core #(.WIDTH(WIDTH)) u_core (
        .x (sel_data),
        .y (rev_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= ID_B;
            rsp_data_q <= '0;
            rsp_id_q   <= ID_A;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            rsp_data_q <= rsp_data_n;
            rsp_id_q   <= rsp_id_n;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        rsp_data_n   = rsp_data_q;
        rsp_id_n     = rsp_id_q;
        if (ready_a || ready_b) begin
            state_n      = ST_HOLD;
            rsp_data_n   = rev_data;
            rsp_id_n     = ready_b ? ID_B : ID_A;
            last_grant_n = ready_b ? ID_B : ID_A;
        end else if (state == ST_HOLD && bus.rsp_ready) begin
            state_n = ST_IDLE;
        end
    end

    assign bus.a_ready   = ready_a;
    assign bus.b_ready   = ready_b;
    assign bus.rsp_valid = (state == ST_HOLD);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

`ifdef REVERSE_ARB_STATS_EN
    // Saturating per-requester transfer counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_grant_cnt <= '0;
            b_grant_cnt <= '0;
        end else begin
            if (ready_a && a_grant_cnt != '1) a_grant_cnt <= a_grant_cnt + CNT_W'(1);
            if (ready_b && b_grant_cnt != '1) b_grant_cnt <= b_grant_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reverse_bits_arbiter.sv
// Directed self-checking bench for reverse_bits_arbiter (also covers REVERSE_ARB_STATS_EN when defined).
module tb_reverse_bits_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reverse_bits_arbiter_if #(.WIDTH(8)) bus ();

`ifdef REVERSE_ARB_STATS_EN
    logic [1:0] a_grant_cnt;
    logic [1:0] b_grant_cnt;

    reverse_bits_arbiter #(.WIDTH(8), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .a_grant_cnt (a_grant_cnt),
        .b_grant_cnt (b_grant_cnt)
    );
`else
    reverse_bits_arbiter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; drive and sample happen 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [7:0] d, input logic id);
        check({tag, ".valid"}, 32'(bus.rsp_valid), 32'(v));
        check({tag, ".data"},  32'(bus.rsp_data),  32'(d));
        check({tag, ".id"},    32'(bus.rsp_id),    32'(id));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    logic [7:0] stream_in  [3];
    logic [7:0] stream_out [3];

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h01;
        bus.b_valid   = 1'b1;
        bus.b_data    = 8'h02;
        bus.rsp_ready = 1'b1;
        #12;
        // Reset state, and no ready while rst is held even with valids up.
        check_rsp("reset", 1'b0, 8'h00, 1'b0);
        check("reset.a_ready", 32'(bus.a_ready), 32'd0);
        check("reset.b_ready", 32'(bus.b_ready), 32'd0);
        bus.b_valid = 1'b0;
        rst = 1'b0;
        #1;

        // Single A request: accepted combinationally, result one edge later.
        check("single.a_ready", 32'(bus.a_ready), 32'd1);
        check("single.b_ready", 32'(bus.b_ready), 32'd0);
        tick();
        bus.a_valid = 1'b0;
        #1;
        check_rsp("single.rsp", 1'b1, 8'h80, 1'b0);
        tick();
        check("single.drain", 32'(bus.rsp_valid), 32'd0);

        // Contention after reset: A first, then strict alternation.
        do_reset();
        bus.a_valid = 1'b1;
        bus.a_data  = 8'hF0;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h0C;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr%0d.a_ready", i), 32'(bus.a_ready), 32'((i % 2) == 0));
            check($sformatf("rr%0d.b_ready", i), 32'(bus.b_ready), 32'((i % 2) == 1));
            tick();
            if ((i % 2) == 0) check_rsp($sformatf("rr%0d", i), 1'b1, 8'h0F, 1'b0);
            else              check_rsp($sformatf("rr%0d", i), 1'b1, 8'h30, 1'b1);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        check("rr.drain", 32'(bus.rsp_valid), 32'd0);

        // B alone is granted; rsp_ready in IDLE has no effect.
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h81;
        #1;
        check("bonly.b_ready", 32'(bus.b_ready), 32'd1);
        tick();
        bus.b_valid = 1'b0;
        #1;
        check_rsp("bonly.rsp", 1'b1, 8'h81, 1'b1);

        // Backpressure: response held, no ready while the consumer stalls.
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h05;
        #1;
        tick();
        check_rsp("bp.load", 1'b1, 8'hA0, 1'b0);
        bus.rsp_ready = 1'b0;
        bus.a_data    = 8'h03;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.a_ready", i), 32'(bus.a_ready), 32'd0);
            check($sformatf("bp%0d.b_ready", i), 32'(bus.b_ready), 32'd0);
            tick();
            check_rsp($sformatf("bp%0d.hold", i), 1'b1, 8'hA0, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp.release.a_ready", 32'(bus.a_ready), 32'd1);
        tick();
        check_rsp("bp.next", 1'b1, 8'hC0, 1'b0);

        // Back-to-back stream from A at one word per cycle.
        stream_in[0]  = 8'h01; stream_in[1]  = 8'h02; stream_in[2]  = 8'h03;
        stream_out[0] = 8'h80; stream_out[1] = 8'h40; stream_out[2] = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            bus.a_data = stream_in[i];
            #1;
            check($sformatf("b2b%0d.a_ready", i), 32'(bus.a_ready), 32'd1);
            tick();
            check_rsp($sformatf("b2b%0d", i), 1'b1, stream_out[i], 1'b0);
        end

        // Reset mid-HOLD clears the response asynchronously and restores A priority.
        bus.a_data = 8'h55;
        tick();
        bus.a_valid = 1'b0;
        #1;
        check_rsp("mid.load", 1'b1, 8'hAA, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_rsp("mid.reset", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h01;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h02;
        #1;
        check("mid.tie.a_ready", 32'(bus.a_ready), 32'd1);
        check("mid.tie.b_ready", 32'(bus.b_ready), 32'd0);
        tick();
        check_rsp("mid.tie", 1'b1, 8'h80, 1'b0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();

`ifdef REVERSE_ARB_STATS_EN
        // Five A transfers saturate a 2-bit counter; B stays at zero.
        do_reset();
        check("stats.reset.a", 32'(a_grant_cnt), 32'd0);
        bus.a_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.a_valid = 1'b0;
        tick();
        check("stats.a_sat", 32'(a_grant_cnt), 32'd3);
        check("stats.b_zero", 32'(b_grant_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
